// File: rtl/sgmii_pkg.sv
// -----------------------------------------------------------------------------
// sgmii_pkg
// Shared definitions for the serial receive deframer:
//   - state_t / ST_*  : deframer FSM state encoding
//   - PREAMBLE_BYTE   : preamble octet (0x55)
//   - SFD_BYTE        : start-of-frame delimiter octet (0xD5)
//   - CRC_POLY        : reflected CRC-32 polynomial
//   - CRC_INIT        : CRC-32 register seed
//   - CRC_RESIDUE     : good-frame CRC-32 residue, normal (MSB-first) bit order
//   - LEN_W           : width of the frame length / byte counter
//   - bit_reverse32() : converts between reflected and normal bit order
// -----------------------------------------------------------------------------
package sgmii_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_PREAMBLE = 2'd1;
    localparam state_t ST_DATA     = 2'd2;
    localparam state_t ST_DROP     = 2'd3;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    localparam int LEN_W = 11;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// -----------------------------------------------------------------------------
// crc32_byte
// Combinational byte-wide update of a reflected (LSB-first) CRC-32 register.
// Ports:
//   crc      in  32  current CRC register
//   data     in   8  byte to fold in (bit 0 is the first bit on the wire)
//   next_crc out 32  CRC register after absorbing data
// -----------------------------------------------------------------------------
module crc32_byte
    import sgmii_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] next_crc
);

    // w_stage[k] is the register after k of the 8 bit-serial steps.
    logic [31:0] w_stage [0:8];

    assign w_stage[0] = crc ^ {24'd0, data};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign w_stage[gi+1] = w_stage[gi][0] ? ((w_stage[gi] >> 1) ^ CRC_POLY)
                                                  : (w_stage[gi] >> 1);
        end
    endgenerate

    assign next_crc = w_stage[8];

endmodule

// File: rtl/sgmii_rx_deframer.sv
// -----------------------------------------------------------------------------
// sgmii_rx_deframer
// Serial-to-byte receive deframer: hunts for preamble + SFD, assembles LSB-first
// bytes, checks CRC-32, minimum/maximum length and trailing partial bits, and
// emits one byte per strobe with sof/eof/err framing flags.
// Parameters:
//   MAX_LEN  maximum accepted frame length in bytes (FCS included)
//   MIN_LEN  minimum accepted frame length in bytes (FCS included)
// Ports:
//   clock      in   1  bit clock, one rx_bit sampled per rising edge
//   reset_n    in   1  asynchronous active-low reset
//   rx_bit     in   1  serial data, byte-wise LSB first
//   rx_dv      in   1  qualifier for rx_bit
//   out_data   out  8  received byte
//   out_valid  out  1  strobe qualifying out_data/out_sof/out_eof/out_err
//   out_sof    out  1  first byte of the frame
//   out_eof    out  1  last byte of the frame
//   out_err    out  1  frame bad (meaningful with out_eof)
//   out_len    out 11  frame byte count (valid with out_eof)
// -----------------------------------------------------------------------------
module sgmii_rx_deframer
    import sgmii_pkg::*;
#(
    parameter int MAX_LEN = 1522,
    parameter int MIN_LEN = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             rx_bit,
    input  logic             rx_dv,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_err,
    output logic [LEN_W-1:0] out_len
);

    state_t           r_state;
    logic [7:0]       r_win;
    logic [2:0]       r_bit_cnt;
    logic [LEN_W-1:0] r_byte_cnt;
    logic [31:0]      r_crc;

    // Most recent complete byte, held until the next byte or the end of rx_dv
    // tells us whether it is the last one.
    logic [7:0]       r_hold_data;
    logic             r_hold_sof;
    logic             r_hold_valid;

    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_out_sof;
    logic             r_out_eof;
    logic             r_out_err;
    logic [LEN_W-1:0] r_out_len;

    logic [7:0]       w_win_next;
    logic [31:0]      w_crc_next;
    logic             w_eof_err;
    logic             w_at_max;

    assign w_win_next = {rx_bit, r_win[7:1]};

    crc32_byte u_crc (
        .crc      (r_crc),
        .data     (w_win_next),
        .next_crc (w_crc_next)
    );

    // The register runs in reflected order while the residue constant is in
    // normal order, so the register is bit-reversed before the compare.
    assign w_eof_err = (bit_reverse32(r_crc) != CRC_RESIDUE)
                    || (r_byte_cnt < LEN_W'(MIN_LEN))
                    || (r_bit_cnt != 3'd0);

    // A byte completing while MAX_LEN bytes are already counted would be
    // byte MAX_LEN+1.
    assign w_at_max = (r_byte_cnt == LEN_W'(MAX_LEN));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_win        <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_crc        <= CRC_INIT;
            r_hold_data  <= '0;
            r_hold_sof   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_sof    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_out_err    <= 1'b0;
            r_out_len    <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;

            if (!rx_dv) begin
                // Clearing the window keeps stale frame bits from forming a
                // false preamble match at the start of the next burst.
                r_win        <= '0;
                r_bit_cnt    <= '0;
                r_hold_valid <= 1'b0;
                r_state      <= ST_IDLE;
                if ((r_state == ST_DATA) && r_hold_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_hold_data;
                    r_out_sof   <= r_hold_sof;
                    r_out_eof   <= 1'b1;
                    r_out_err   <= w_eof_err;
                    r_out_len   <= r_byte_cnt;
                end
            end else begin
                r_win <= w_win_next;
                case (r_state)
                    ST_IDLE: begin
                        if (w_win_next == PREAMBLE_BYTE) begin
                            r_state   <= ST_PREAMBLE;
                            r_bit_cnt <= '0;
                        end
                    end

                    ST_PREAMBLE: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_win_next == SFD_BYTE) begin
                                r_state      <= ST_DATA;
                                r_bit_cnt    <= '0;
                                r_byte_cnt   <= '0;
                                r_crc        <= CRC_INIT;
                                r_hold_valid <= 1'b0;
                            end else if (w_win_next != PREAMBLE_BYTE) begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end

                    ST_DATA: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_at_max) begin
                                // Oversize: close the frame on the held byte
                                // and swallow the rest of the burst.
                                r_out_valid  <= 1'b1;
                                r_out_data   <= r_hold_data;
                                r_out_sof    <= r_hold_sof;
                                r_out_eof    <= 1'b1;
                                r_out_err    <= 1'b1;
                                r_out_len    <= r_byte_cnt;
                                r_hold_valid <= 1'b0;
                                r_state      <= ST_DROP;
                            end else begin
                                if (r_hold_valid) begin
                                    r_out_valid <= 1'b1;
                                    r_out_data  <= r_hold_data;
                                    r_out_sof   <= r_hold_sof;
                                    r_out_err   <= 1'b0;
                                end
                                r_hold_data  <= w_win_next;
                                r_hold_sof   <= (r_byte_cnt == '0);
                                r_hold_valid <= 1'b1;
                                r_byte_cnt   <= r_byte_cnt + LEN_W'(1);
                                r_crc        <= w_crc_next;
                            end
                        end
                    end

                    ST_DROP: begin
                        // Stay silent until rx_dv drops.
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign out_err   = r_out_err;
    assign out_len   = r_out_len;

endmodule

// File: tb/tb_sgmii_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_sgmii_rx_deframer
// Directed bench for sgmii_rx_deframer: builds frames with a bench-computed
// FCS, shifts them in LSB first behind 7x0x55 + 0xD5, records every output
// strobe and checks counts, framing flags, length, error and data per scenario.
// -----------------------------------------------------------------------------
module tb_sgmii_rx_deframer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rx_bit;
    logic        rx_dv;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        out_err;
    logic [10:0] out_len;

    int checks = 0;
    int errors = 0;

    sgmii_rx_deframer #(.MAX_LEN(1522), .MIN_LEN(64)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx_bit    (rx_bit),
        .rx_dv     (rx_dv),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_err   (out_err),
        .out_len   (out_len)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic        err;
        logic [10:0] len;
    } ev_t;

    ev_t        cap_q[$];
    logic [7:0] sent_q[$];

    // Record every output strobe shortly after the active edge.
    always @(posedge clock) begin
        ev_t e;
        #1;
        if (out_valid === 1'b1) begin
            e.d   = out_data;
            e.sof = out_sof;
            e.eof = out_eof;
            e.err = out_err;
            e.len = out_len;
            cap_q.push_back(e);
        end
    end

    // Statistics gathered from cap_q by summarize()
    int          cap_n, sof_cnt, eof_cnt, eof_err_cnt, last_eof_idx, data_bad;
    logic        sof_first, last_eof_err;
    logic [10:0] last_eof_len;

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // len total bytes; with_fcs appends a correct FCS as the last 4 bytes.
    task automatic build_frame(input int len, input bit with_fcs, input int flip_idx);
        logic [31:0] c;
        int          n;
        sent_q.delete();
        n = with_fcs ? len - 4 : len;
        for (int i = 0; i < n; i++) sent_q.push_back(8'((i * 37 + 11) & 255));
        if (with_fcs) begin
            c = 32'hFFFFFFFF;
            for (int i = 0; i < n; i++) c = crc_upd(c, sent_q[i]);
            c = ~c;
            for (int i = 0; i < 4; i++) sent_q.push_back(8'(c >> (8 * i)));
        end
        if (flip_idx >= 0) sent_q[flip_idx] = sent_q[flip_idx] ^ 8'h08;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clock);
        rx_dv  = 1'b1;
        rx_bit = b;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int k = 0; k < 8; k++) send_bit(v[k]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            rx_dv  = 1'b0;
            rx_bit = 1'b0;
        end
    endtask

    task automatic send_preamble();
        repeat (7) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    task automatic send_frame(input int extra_bits);
        send_preamble();
        foreach (sent_q[i]) send_byte(sent_q[i]);
        for (int k = 0; k < extra_bits; k++) send_bit(k[0]);
    endtask

    task automatic summarize();
        int n;
        n            = sent_q.size();
        cap_n        = cap_q.size();
        sof_cnt      = 0;
        eof_cnt      = 0;
        eof_err_cnt  = 0;
        last_eof_idx = -1;
        last_eof_err = 1'b0;
        last_eof_len = '0;
        data_bad     = 0;
        sof_first    = (cap_n > 0) ? cap_q[0].sof : 1'b0;
        foreach (cap_q[i]) begin
            if (cap_q[i].sof) sof_cnt++;
            if (cap_q[i].eof) begin
                eof_cnt++;
                if (cap_q[i].err) eof_err_cnt++;
                last_eof_idx = i;
                last_eof_err = cap_q[i].err;
                last_eof_len = cap_q[i].len;
            end
            if (n > 0 && cap_q[i].d !== sent_q[i % n]) data_bad++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx_dv   = 1'b0;
        rx_bit  = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({out_valid, out_sof, out_eof, out_err, out_data, out_len} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {out_valid, out_sof, out_eof, out_err, out_data, out_len});
        end
        reset_n = 1'b1;
        idle(2);
        $display("reset: outputs checked");
    endtask

    task automatic test_no_preamble();
        cap_q.delete();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'hD5);
        repeat (8) send_byte(8'h00);
        idle(4);
        summarize();
        checks++;
        if (cap_n !== 0) begin
            errors++; $display("FAIL no_preamble_count: got %0d required 0", cap_n);
        end
        $display("no_preamble: %0d bytes out", cap_n);
    endtask

    task automatic test_good_frame();
        cap_q.delete();
        build_frame(64, 1'b1, -1);
        send_frame(0);
        idle(4);
        summarize();
        checks++;
        if (cap_n !== 64) begin errors++; $display("FAIL good_count: got %0d required 64", cap_n); end
        checks++;
        if (sof_first !== 1'b1 || sof_cnt !== 1) begin
            errors++; $display("FAIL good_sof: first=%0b count=%0d required 1/1", sof_first, sof_cnt);
        end
        checks++;
        if (eof_cnt !== 1 || last_eof_idx !== 63) begin
            errors++; $display("FAIL good_eof: count=%0d idx=%0d required 1/63", eof_cnt, last_eof_idx);
        end
        checks++;
        if (last_eof_err !== 1'b0) begin errors++; $display("FAIL good_err: got %0b required 0", last_eof_err); end
        checks++;
        if (last_eof_len !== 11'd64) begin errors++; $display("FAIL good_len: got %0d required 64", last_eof_len); end
        checks++;
        if (data_bad !== 0) begin errors++; $display("FAIL good_data: %0d bytes differ, required 0", data_bad); end
        checks++;
        if (out_valid !== 1'b0 || out_len !== 11'd64 || out_data !== sent_q[63]) begin
            errors++; $display("FAIL good_hold: valid=%0b len=%0d data=%h required 0/64/%h",
                               out_valid, out_len, out_data, sent_q[63]);
        end
        $display("good_frame: %0d bytes, err=%0b len=%0d", cap_n, last_eof_err, last_eof_len);
    endtask

    task automatic test_crc_error();
        cap_q.delete();
        build_frame(64, 1'b1, 9);
        send_frame(0);
        idle(4);
        summarize();
        checks++;
        if (cap_n !== 64 || eof_cnt !== 1) begin
            errors++; $display("FAIL crc_count: bytes=%0d eofs=%0d required 64/1", cap_n, eof_cnt);
        end
        checks++;
        if (last_eof_err !== 1'b1 || last_eof_len !== 11'd64) begin
            errors++; $display("FAIL crc_err: err=%0b len=%0d required 1/64", last_eof_err, last_eof_len);
        end
        $display("crc_error: %0d bytes, err=%0b len=%0d", cap_n, last_eof_err, last_eof_len);
    endtask

    task automatic test_short_frame();
        cap_q.delete();
        build_frame(60, 1'b1, -1);
        send_frame(0);
        idle(4);
        summarize();
        checks++;
        if (cap_n !== 60 || last_eof_idx !== 59) begin
            errors++; $display("FAIL short_count: bytes=%0d eof_idx=%0d required 60/59", cap_n, last_eof_idx);
        end
        checks++;
        if (last_eof_err !== 1'b1 || last_eof_len !== 11'd60) begin
            errors++; $display("FAIL short_err: err=%0b len=%0d required 1/60", last_eof_err, last_eof_len);
        end
        $display("short_frame: %0d bytes, err=%0b len=%0d", cap_n, last_eof_err, last_eof_len);
    endtask

    task automatic test_extra_bits();
        cap_q.delete();
        build_frame(64, 1'b1, -1);
        send_frame(5);
        idle(4);
        summarize();
        checks++;
        if (cap_n !== 64 || last_eof_idx !== 63 || data_bad !== 0) begin
            errors++; $display("FAIL extra_count: bytes=%0d eof_idx=%0d bad=%0d required 64/63/0",
                               cap_n, last_eof_idx, data_bad);
        end
        checks++;
        if (last_eof_err !== 1'b1 || last_eof_len !== 11'd64) begin
            errors++; $display("FAIL extra_err: err=%0b len=%0d required 1/64", last_eof_err, last_eof_len);
        end
        $display("extra_bits: %0d bytes, err=%0b len=%0d", cap_n, last_eof_err, last_eof_len);
    endtask

    task automatic test_short_abort();
        cap_q.delete();
        send_preamble();
        for (int k = 0; k < 3; k++) send_bit(1'b1);
        idle(4);
        summarize();
        checks++;
        if (cap_n !== 0) begin errors++; $display("FAIL abort_count: got %0d required 0", cap_n); end
        $display("short_abort: %0d bytes out", cap_n);
    endtask

    task automatic test_overflow();
        cap_q.delete();
        build_frame(1600, 1'b0, -1);
        send_frame(0);
        idle(4);
        summarize();
        checks++;
        if (cap_n !== 1522 || data_bad !== 0) begin
            errors++; $display("FAIL ovf_count: bytes=%0d bad=%0d required 1522/0", cap_n, data_bad);
        end
        checks++;
        if (eof_cnt !== 1 || last_eof_idx !== 1521) begin
            errors++; $display("FAIL ovf_eof: count=%0d idx=%0d required 1/1521", eof_cnt, last_eof_idx);
        end
        checks++;
        if (last_eof_err !== 1'b1 || last_eof_len !== 11'd1522) begin
            errors++; $display("FAIL ovf_err: err=%0b len=%0d required 1/1522", last_eof_err, last_eof_len);
        end
        $display("overflow: %0d bytes, err=%0b len=%0d", cap_n, last_eof_err, last_eof_len);

        cap_q.delete();
        build_frame(64, 1'b1, -1);
        send_frame(0);
        idle(4);
        summarize();
        checks++;
        if (cap_n !== 64 || eof_cnt !== 1 || eof_err_cnt !== 0 || data_bad !== 0) begin
            errors++; $display("FAIL ovf_next: bytes=%0d eofs=%0d errs=%0d bad=%0d required 64/1/0/0",
                               cap_n, eof_cnt, eof_err_cnt, data_bad);
        end
        $display("after_overflow: %0d bytes, err=%0b len=%0d", cap_n, last_eof_err, last_eof_len);
    endtask

    task automatic test_reset_mid_frame();
        cap_q.delete();
        build_frame(64, 1'b1, -1);
        send_preamble();
        for (int i = 0; i < 30; i++) send_byte(sent_q[i]);
        @(negedge clock);
        reset_n = 1'b0;
        rx_dv   = 1'b0;
        rx_bit  = 1'b0;
        #2;
        checks++;
        if ({out_valid, out_sof, out_eof, out_err, out_data, out_len} !== 23'd0) begin
            errors++; $display("FAIL midreset_outputs: got %h required 0",
                               {out_valid, out_sof, out_eof, out_err, out_data, out_len});
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        idle(4);
        summarize();
        checks++;
        if (cap_n !== 29 || eof_cnt !== 0) begin
            errors++; $display("FAIL midreset_abort: bytes=%0d eofs=%0d required 29/0", cap_n, eof_cnt);
        end
        $display("reset_mid_frame: %0d bytes before reset, eofs=%0d", cap_n, eof_cnt);

        cap_q.delete();
        send_frame(0);
        idle(4);
        summarize();
        checks++;
        if (cap_n !== 64 || eof_cnt !== 1 || last_eof_err !== 1'b0 || last_eof_len !== 11'd64) begin
            errors++; $display("FAIL midreset_next: bytes=%0d eofs=%0d err=%0b len=%0d required 64/1/0/64",
                               cap_n, eof_cnt, last_eof_err, last_eof_len);
        end
        $display("after_reset: %0d bytes, err=%0b len=%0d", cap_n, last_eof_err, last_eof_len);
    endtask

    task automatic test_back_to_back();
        cap_q.delete();
        build_frame(64, 1'b1, -1);
        send_frame(0);
        idle(1);
        send_frame(0);
        idle(4);
        summarize();
        checks++;
        if (cap_n !== 128 || data_bad !== 0) begin
            errors++; $display("FAIL b2b_count: bytes=%0d bad=%0d required 128/0", cap_n, data_bad);
        end
        checks++;
        if (sof_cnt !== 2 || eof_cnt !== 2 || eof_err_cnt !== 0) begin
            errors++; $display("FAIL b2b_flags: sofs=%0d eofs=%0d errs=%0d required 2/2/0",
                               sof_cnt, eof_cnt, eof_err_cnt);
        end
        $display("back_to_back: %0d bytes, %0d frames", cap_n, eof_cnt);
    endtask

    initial begin
        rx_dv   = 1'b0;
        rx_bit  = 1'b0;
        reset_n = 1'b0;
        test_reset();
        test_no_preamble();
        test_good_frame();
        test_crc_error();
        test_short_frame();
        test_extra_bits();
        test_short_abort();
        test_overflow();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
